alu_multicycle_core: RTL and testbench

//  Parametrised multi-cycle ALU core: accepts one 16-bit instruction per handshake, reads two operands from an internal

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_multicycle_core_if.sv | 28 ++
 rtl/alu_regbank.sv | 39 +++
 rtl/alu_multicycle_core.sv | 165 ++++++++++++++++
 tb/tb_alu_multicycle_core.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU core: instruction field layout,
// opcode and FSM state encodings, and opcode classification helpers.
package alu_pkg;

   localparam int INSTR_W = 16;
   localparam int FIELD_W = 4;
   localparam int OPC_LO  = 12;
   localparam int RD_LO   = 8;
   localparam int RS_LO   = 4;
   localparam int RT_LO   = 0;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_SLTI = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_ANDI = 4'h6,
      OP_ORI  = 4'h7,
      OP_XORI = 4'h8,
      OP_ADDI = 4'h9,
      OP_SUBI = 4'hA
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_READ,
      S_EXEC,
      S_WB
   } state_e;

   // Immediate forms take their second operand from the rs field.
   function automatic logic is_imm(input logic [3:0] op);
      return (op == OP_SLTI) || ((op >= OP_ANDI) && (op <= OP_SUBI));
   endfunction

   function automatic logic is_legal(input logic [3:0] op);
      return op <= OP_SUBI;
   endfunction

endpackage

// File: rtl/alu_multicycle_core_if.sv
// Instruction-issue and writeback bus of the multi-cycle ALU core.
interface alu_multicycle_core_if
   import alu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16
);
   localparam int REG_AW = $clog2(NREGS);

   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ready;
   logic               wb_valid;
   logic [REG_AW-1:0]  wb_addr;
   logic [DATA_W-1:0]  wb_data;
   logic               illegal;

   modport master (
      output instr, instr_valid,
      input  instr_ready, wb_valid, wb_addr, wb_data, illegal
   );

   modport slave (
      input  instr, instr_valid,
      output instr_ready, wb_valid, wb_addr, wb_data, illegal
   );

endinterface

// File: rtl/alu_regbank.sv
// NREGS x DATA_W register bank: two registered read ports, one write port,
// and an asynchronous debug read port that does not see same-cycle writes.
module alu_regbank #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     re,
   input  logic [$clog2(NREGS)-1:0] ra_addr,
   output logic [DATA_W-1:0]        ra_data,
   input  logic [$clog2(NREGS)-1:0] rb_addr,
   output logic [DATA_W-1:0]        rb_data,
   input  logic                     we,
   input  logic [$clog2(NREGS)-1:0] wa,
   input  logic [DATA_W-1:0]        wd,
   input  logic [$clog2(NREGS)-1:0] dbg_addr,
   output logic [DATA_W-1:0]        dbg_data
);

   logic [DATA_W-1:0] mem [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[wa] <= wd;
      end
      if (re) begin
         ra_data <= mem[ra_addr];
         rb_data <= mem[rb_addr];
      end
   end

   assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_multicycle_core.sv
// Multi-cycle ALU core: IDLE -> DECODE -> READ -> EXEC -> WB, one instruction per 5 cycles.
// Define ALU_FLAGS_EN to add the {N,Z,C,V} flags port and its update logic.
module alu_multicycle_core
   import alu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   alu_multicycle_core_if.slave     bus,
   input  logic [$clog2(NREGS)-1:0] dbg_addr,
   output logic [DATA_W-1:0]        dbg_data
`ifdef ALU_FLAGS_EN
   ,
   output logic [3:0]               flags
`endif
);

   localparam int REG_AW = $clog2(NREGS);
   localparam int MSB    = DATA_W - 1;

   state_e             state_q, state_d;
   logic               ready_c, wb_c, illegal_c;
   logic [INSTR_W-1:0] instr_p0;
   opcode_e            op;
   logic [DATA_W-1:0]  rs_val_p1, rt_val_p1;
   logic [DATA_W-1:0]  imm, opx, opy, sum, dif, res;
   logic               imm_op;
   logic [REG_AW-1:0]  rd_p2;
   logic [DATA_W-1:0]  result_p2;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      ready_c   = 1'b0;
      wb_c      = 1'b0;
      illegal_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready_c = 1'b1;
            if (bus.instr_valid) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_legal(instr_p0[OPC_LO +: FIELD_W])) begin
               state_d = S_READ;
            end else begin
               illegal_c = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_READ:  state_d = S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_WB: begin
            wb_c    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stage p0: instruction captured on accept, held while busy
   always_ff @(posedge clk) begin
      if ((state_q == S_IDLE) && bus.instr_valid) instr_p0 <= bus.instr;
   end

   // Stage p1: operands read from the bank during READ, visible in EXEC
   alu_regbank #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regbank (
      .clk      (clk),
      .rst      (rst),
      .re       (state_q == S_READ),
      .ra_addr  (instr_p0[RS_LO +: REG_AW]),
      .ra_data  (rs_val_p1),
      .rb_addr  (instr_p0[RT_LO +: REG_AW]),
      .rb_data  (rt_val_p1),
      .we       (wb_c),
      .wa       (rd_p2),
      .wd       (result_p2),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   assign op     = opcode_e'(instr_p0[OPC_LO +: FIELD_W]);
   assign imm_op = is_imm(instr_p0[OPC_LO +: FIELD_W]);
   assign imm    = DATA_W'(instr_p0[RS_LO +: FIELD_W]);
   assign opx    = imm_op ? rt_val_p1 : rs_val_p1;
   assign opy    = imm_op ? imm : rt_val_p1;

`ifdef ALU_FLAGS_EN
   logic [DATA_W:0] sum_w, dif_w;
   logic            c_x, v_x;
   logic [3:0]      flags_p2;

   assign sum_w = {1'b0, opx} + {1'b0, opy};
   assign dif_w = {1'b0, opx} - {1'b0, opy};
   assign sum   = sum_w[MSB:0];
   assign dif   = dif_w[MSB:0];

   // C is carry-out for additions and borrow for subtractions
   always_comb begin
      c_x = 1'b0;
      v_x = 1'b0;
      case (op)
         OP_ADD, OP_ADDI: begin
            c_x = sum_w[DATA_W];
            v_x = (opx[MSB] == opy[MSB]) && (sum[MSB] != opx[MSB]);
         end
         OP_SUB, OP_SUBI: begin
            c_x = dif_w[DATA_W];
            v_x = (opx[MSB] != opy[MSB]) && (dif[MSB] != opx[MSB]);
         end
         default: ;
      endcase
   end
`else
   assign sum = opx + opy;
   assign dif = opx - opy;
`endif

   always_comb begin
      res = '0;
      case (op)
         OP_ADD, OP_ADDI: res = sum;
         OP_SUB, OP_SUBI: res = dif;
         OP_AND, OP_ANDI: res = opx & opy;
         OP_OR,  OP_ORI:  res = opx | opy;
         OP_XOR, OP_XORI: res = opx ^ opy;
         OP_SLTI:         res = DATA_W'(opx < opy);
         default:         res = '0;
      endcase
   end

   // Stage p2: result registered at the end of EXEC, written back in WB
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_p2     <= '0;
         result_p2 <= '0;
      end else if (state_q == S_EXEC) begin
         rd_p2     <= instr_p0[RD_LO +: REG_AW];
         result_p2 <= res;
      end
   end

`ifdef ALU_FLAGS_EN
   always_ff @(posedge clk) begin
      if (state_q == S_EXEC) flags_p2 <= {res[MSB], (res == '0), c_x, v_x};
   end

   always_ff @(posedge clk) begin
      if (rst)       flags <= '0;
      else if (wb_c) flags <= flags_p2;
   end
`endif

   assign bus.instr_ready = ready_c;
   assign bus.wb_valid    = wb_c;
   assign bus.illegal     = illegal_c;
   assign bus.wb_addr     = rd_p2;
   assign bus.wb_data     = result_p2;

endmodule

// File: tb/tb_alu_multicycle_core.sv
// Directed bench for alu_multicycle_core; flag checks are active when ALU_FLAGS_EN is defined.
module tb_alu_multicycle_core;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] dbg_addr;
   logic [15:0] dbg_data;
`ifdef ALU_FLAGS_EN
   logic [3:0] flags;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   alu_multicycle_core_if #(.DATA_W(16), .NREGS(16)) bus ();

   alu_multicycle_core #(.DATA_W(16), .NREGS(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
`ifdef ALU_FLAGS_EN
      ,
      .flags    (flags)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_flags(input string tag, input logic [3:0] exp);
`ifdef ALU_FLAGS_EN
      check(tag, 32'(flags), 32'(exp));
`else
      if (exp === 4'bxxxx) $display("[TB] %s", tag);
`endif
   endtask

   // Issue one instruction from IDLE and follow it through to writeback.
   task automatic run_op(input logic [15:0] ins, input logic [3:0] exp_addr,
                         input logic [15:0] exp_data, input logic [15:0] old_data,
                         input logic [3:0] exp_flags, input string tag);
      dbg_addr        = exp_addr;
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      check({tag, "_ready"}, 32'(bus.instr_ready), 32'd1);
      tick();
      bus.instr_valid = 1'b0;
      check({tag, "_dec_wb"}, 32'(bus.wb_valid), 32'd0);
      check({tag, "_dec_ill"}, 32'(bus.illegal), 32'd0);
      tick();
      check({tag, "_rd_wb"}, 32'(bus.wb_valid), 32'd0);
      tick();
      check({tag, "_ex_wb"}, 32'(bus.wb_valid), 32'd0);
      tick();
      check({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
      check({tag, "_wb_addr"}, 32'(bus.wb_addr), 32'(exp_addr));
      check({tag, "_wb_data"}, 32'(bus.wb_data), 32'(exp_data));
      check({tag, "_dbg_old"}, 32'(dbg_data), 32'(old_data));
      tick();
      check({tag, "_wb_end"}, 32'(bus.wb_valid), 32'd0);
      check({tag, "_idle"}, 32'(bus.instr_ready), 32'd1);
      check({tag, "_dbg_new"}, 32'(dbg_data), 32'(exp_data));
      check_flags({tag, "_flags"}, exp_flags);
   endtask

   initial begin
      logic [15:0] prog [3];
      int          acc_cyc [3];
      int          wb_cyc  [3];
      logic [15:0] wb_dat  [3];
      logic [3:0]  wb_adr  [3];
      int          idx;
      int          nwb;
      int          pulses;

      rst             = 1'b1;
      bus.instr       = '0;
      bus.instr_valid = 1'b0;
      dbg_addr        = 4'd1;
      tick();
      tick();
      tick();
      rst = 1'b0;
      check("rst_ready", 32'(bus.instr_ready), 32'd1);
      check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      check("rst_illegal", 32'(bus.illegal), 32'd0);
      check("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
      check("rst_wb_data", 32'(bus.wb_data), 32'd0);
      check("rst_r1", 32'(dbg_data), 32'd0);
      check_flags("rst_flags", 4'b0000);

      run_op(16'h9150, 4'd1, 16'h0005, 16'h0000, 4'b0000, "addi_r1");
      run_op(16'h9230, 4'd2, 16'h0003, 16'h0000, 4'b0000, "addi_r2");
      run_op(16'h1321, 4'd3, 16'hFFFE, 16'h0000, 4'b1010, "sub_wrap");
      run_op(16'h3472, 4'd4, 16'h0001, 16'h0000, 4'b0000, "slti_true");
      run_op(16'h3422, 4'd4, 16'h0000, 16'h0001, 4'b0100, "slti_false");
      run_op(16'h0613, 4'd6, 16'h0003, 16'h0000, 4'b0010, "add_carry");

      // Illegal opcode 0xC: pulse in DECODE, no writeback, ready two cycles after accept
      dbg_addr        = 4'd1;
      bus.instr       = 16'hC123;
      bus.instr_valid = 1'b1;
      tick();
      bus.instr_valid = 1'b0;
      check("ill_pulse", 32'(bus.illegal), 32'd1);
      check("ill_no_wb", 32'(bus.wb_valid), 32'd0);
      check("ill_busy", 32'(bus.instr_ready), 32'd0);
      tick();
      check("ill_ready", 32'(bus.instr_ready), 32'd1);
      check("ill_end", 32'(bus.illegal), 32'd0);
      check("ill_r1", 32'(dbg_data), 32'h0005);
      check_flags("ill_flags", 4'b0010);

      run_op(16'h0111, 4'd1, 16'h000A, 16'h0005, 4'b0000, "add_rd_eq_rs");

      // Back-to-back issue with instr_valid held high; instr scribbled while busy
      prog[0] = 16'h9710;
      prog[1] = 16'h88F1;
      prog[2] = 16'h4921;
      idx     = 0;
      nwb     = 0;
      bus.instr_valid = 1'b1;
      for (int c = 0; c < 18; c++) begin
         if (bus.instr_ready) begin
            if (idx < 3) begin
               bus.instr    = prog[idx];
               acc_cyc[idx] = c;
               idx++;
            end else begin
               bus.instr_valid = 1'b0;
            end
         end else begin
            bus.instr = 16'h9FF0 ^ 16'(c);
         end
         if (bus.wb_valid && (nwb < 3)) begin
            wb_cyc[nwb] = c;
            wb_dat[nwb] = bus.wb_data;
            wb_adr[nwb] = bus.wb_addr;
            nwb++;
         end
         tick();
      end
      bus.instr_valid = 1'b0;
      check("tp_accepts", 32'(idx), 32'd3);
      check("tp_wb_count", 32'(nwb), 32'd3);
      check("tp_space01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
      check("tp_space12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd5);
      check("tp_lat0", 32'(wb_cyc[0] - acc_cyc[0]), 32'd4);
      check("tp_lat2", 32'(wb_cyc[2] - acc_cyc[2]), 32'd4);
      check("tp_addr0", 32'(wb_adr[0]), 32'd7);
      check("tp_data0", 32'(wb_dat[0]), 32'h0001);
      check("tp_addr1", 32'(wb_adr[1]), 32'd8);
      check("tp_data1", 32'(wb_dat[1]), 32'h0005);
      check("tp_addr2", 32'(wb_adr[2]), 32'd9);
      check("tp_data2", 32'(wb_dat[2]), 32'h000B);
      dbg_addr = 4'd15;
      #1;
      check("tp_r15_untouched", 32'(dbg_data), 32'd0);

      // Reset asserted while ADD r5 = r1 + r2 is in EXEC
      dbg_addr        = 4'd5;
      bus.instr       = 16'h0512;
      bus.instr_valid = 1'b1;
      tick();
      bus.instr_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_ready", 32'(bus.instr_ready), 32'd1);
      check("mid_rst_wb", 32'(bus.wb_valid), 32'd0);
      check("mid_rst_wb_data", 32'(bus.wb_data), 32'd0);
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         if (bus.wb_valid) pulses++;
         tick();
      end
      check("mid_rst_no_wb", 32'(pulses), 32'd0);
      check("mid_rst_r5", 32'(dbg_data), 32'd0);
      dbg_addr = 4'd1;
      #1;
      check("mid_rst_r1_cleared", 32'(dbg_data), 32'd0);
      check_flags("mid_rst_flags", 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
